// File: rtl/apb_filter_pkg.sv
// Shared definitions for the image-filter APB register block.
//   - one-hot state bit indices for the completer FSM
//   - register addresses
//   - CTRL / STATUS bit positions
package apb_filter_pkg;

  // One-hot state bit indices
  localparam int unsigned ST_IDLE_IDX   = 0;
  localparam int unsigned ST_WAIT_IDX   = 1;  // access phase, wait states still pending
  localparam int unsigned ST_ACCESS_IDX = 2;  // access phase, ready as soon as PENABLE is seen
  localparam int unsigned NUM_STATES    = 3;

  localparam logic [NUM_STATES-1:0] ST_IDLE   = 3'b001;
  localparam logic [NUM_STATES-1:0] ST_WAIT   = 3'b010;
  localparam logic [NUM_STATES-1:0] ST_ACCESS = 3'b100;

  // Register map
  localparam int unsigned ADDR_CTRL   = 0;
  localparam int unsigned ADDR_STATUS = 1;
  localparam int unsigned ADDR_COEF0  = 2;

  // CTRL bits
  localparam int unsigned CTRL_START_BIT  = 0;
  localparam int unsigned CTRL_ENABLE_BIT = 1;
  localparam int unsigned CTRL_MODE_LSB   = 2;

  // STATUS bits
  localparam int unsigned STATUS_BUSY_BIT = 0;
  localparam int unsigned STATUS_DONE_BIT = 1;

endpackage

// File: rtl/apb_wait_cnt.sv
// Load/decrement down-counter with a zero flag, used to time APB wait states.
// Ports:
//   clk_i       clock
//   rst_i       synchronous active-high reset (counter -> 0)
//   load_i      load load_val_i (has priority over decrement)
//   load_val_i  value to load
//   dec_i       decrement by one, saturating at zero
//   cnt_o       current count
//   zero_o      count is zero
module apb_wait_cnt #(
  parameter int unsigned Width = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             dec_i,
  output logic [Width-1:0] cnt_o,
  output logic             zero_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - Width'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/apb_filter_regs.sv
// APB completer holding the image-filter configuration: CTRL, STATUS and a bank of NUM_COEF
// kernel coefficients, with a programmable number of access-phase wait states.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   i_PADDR .. i_PWDATA   APB requester signals
//   o_PREADY/o_PRDATA/o_PSLVERR  APB completer responses
//   i_busy                filter busy, read back as STATUS bit0
//   i_done                filter done pulse, sets sticky STATUS bit1
//   o_start               one-cycle start pulse after a CTRL write with bit0 set
//   o_enable, o_mode      CTRL fields
//   o_coef                coefficient k at [k*DATA_WIDTH +: DATA_WIDTH]
module apb_filter_regs
  import apb_filter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned NUM_COEF    = 9,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned CNT_WIDTH   = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [ADDR_WIDTH-1:0]          i_PADDR,
  input  logic                           i_PSEL,
  input  logic                           i_PENABLE,
  input  logic                           i_PWRITE,
  input  logic [DATA_WIDTH-1:0]          i_PWDATA,
  output logic                           o_PREADY,
  output logic [DATA_WIDTH-1:0]          o_PRDATA,
  output logic                           o_PSLVERR,
  input  logic                           i_busy,
  input  logic                           i_done,
  output logic                           o_start,
  output logic                           o_enable,
  output logic [1:0]                     o_mode,
  output logic [NUM_COEF*DATA_WIDTH-1:0] o_coef
);

  localparam int unsigned NumRegs = ADDR_COEF0 + NUM_COEF;

  logic [NUM_STATES-1:0] state_q, state_d;
  logic                  setup;
  logic                  cnt_load, cnt_dec, cnt_zero;
  logic [CNT_WIDTH-1:0]  cnt;
  logic                  pready;

  logic                  addr_valid, is_ctrl, is_status;
  logic                  wr_commit;
  logic [DATA_WIDTH-1:0] rd_mux;

  logic                  enable_q, enable_d;
  logic [1:0]            mode_q, mode_d;
  logic                  done_q, done_d;
  logic                  start_q, start_d;

  // ---------------------------------------------------------------------------
  // Transfer FSM
  // ---------------------------------------------------------------------------
  assign setup    = i_PSEL & ~i_PENABLE;
  assign cnt_load = state_q[ST_IDLE_IDX] & setup;
  assign cnt_dec  = ~state_q[ST_IDLE_IDX] & i_PSEL;

  apb_wait_cnt #(
    .Width(CNT_WIDTH)
  ) u_wait_cnt (
    .clk_i     (clk),
    .rst_i     (rst),
    .load_i    (cnt_load),
    .load_val_i(CNT_WIDTH'(WAIT_CYCLES)),
    .dec_i     (cnt_dec),
    .cnt_o     (cnt),
    .zero_o    (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      state_q[ST_IDLE_IDX]: begin
        // PSEL & PENABLE without a preceding setup is ignored here.
        if (setup) state_d = (WAIT_CYCLES == 0) ? ST_ACCESS : ST_WAIT;
      end
      state_q[ST_WAIT_IDX]: begin
        if (!i_PSEL) begin
          state_d = ST_IDLE;
        end else if (cnt == CNT_WIDTH'(1)) begin
          state_d = ST_ACCESS;  // counter reaches zero on this edge
        end
      end
      state_q[ST_ACCESS_IDX]: begin
        if (!i_PSEL || pready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pready = state_q[ST_ACCESS_IDX] & cnt_zero & i_PSEL & i_PENABLE;
  end

  // ---------------------------------------------------------------------------
  // Address decode and responses
  // ---------------------------------------------------------------------------
  assign addr_valid = (32'(i_PADDR) < NumRegs);
  assign is_ctrl    = (i_PADDR == ADDR_WIDTH'(ADDR_CTRL));
  assign is_status  = (i_PADDR == ADDR_WIDTH'(ADDR_STATUS));
  assign wr_commit  = pready & i_PWRITE & addr_valid;

  always_comb begin
    rd_mux = '0;
    if (is_ctrl) begin
      rd_mux[CTRL_ENABLE_BIT]        = enable_q;
      rd_mux[CTRL_MODE_LSB +: 2]     = mode_q;
    end else if (is_status) begin
      rd_mux[STATUS_BUSY_BIT]        = i_busy;
      rd_mux[STATUS_DONE_BIT]        = done_q;
    end
    for (int k = 0; k < NUM_COEF; k++) begin
      if (i_PADDR == ADDR_WIDTH'(ADDR_COEF0 + k)) rd_mux = o_coef[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign o_PREADY  = pready;
  assign o_PRDATA  = (pready & ~i_PWRITE & addr_valid) ? rd_mux : '0;
  assign o_PSLVERR = pready & ~addr_valid;

  // ---------------------------------------------------------------------------
  // CTRL / STATUS
  // ---------------------------------------------------------------------------
  always_comb begin
    enable_d = enable_q;
    mode_d   = mode_q;
    done_d   = done_q;
    start_d  = 1'b0;
    if (wr_commit && is_ctrl) begin
      enable_d = i_PWDATA[CTRL_ENABLE_BIT];
      mode_d   = i_PWDATA[CTRL_MODE_LSB +: 2];
      start_d  = i_PWDATA[CTRL_START_BIT];
    end
    if (wr_commit && is_status && i_PWDATA[STATUS_DONE_BIT]) done_d = 1'b0;
    // A done pulse coinciding with a clear must not be lost.
    if (i_done) done_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      enable_q <= 1'b0;
      mode_q   <= 2'b00;
      done_q   <= 1'b0;
      start_q  <= 1'b0;
    end else begin
      enable_q <= enable_d;
      mode_q   <= mode_d;
      done_q   <= done_d;
      start_q  <= start_d;
    end
  end

  assign o_start  = start_q;
  assign o_enable = enable_q;
  assign o_mode   = mode_q;

  // ---------------------------------------------------------------------------
  // Coefficient bank
  // ---------------------------------------------------------------------------
  for (genvar k = 0; k < NUM_COEF; k++) begin : g_coef
    logic                  we;
    logic [DATA_WIDTH-1:0] coef_q;

    assign we = wr_commit & (i_PADDR == ADDR_WIDTH'(ADDR_COEF0 + k));

    always_ff @(posedge clk) begin
      if (rst) begin
        coef_q <= '0;
      end else if (we) begin
        coef_q <= i_PWDATA;
      end
    end

    assign o_coef[k*DATA_WIDTH +: DATA_WIDTH] = coef_q;
  end

endmodule

// File: tb/tb_apb_filter_regs.sv
module tb_apb_filter_regs;

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 8;
  localparam int unsigned NC = 9;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] paddr = '0;
  logic          psel = 1'b0;
  logic          penable = 1'b0;
  logic          pwrite = 1'b0;
  logic [DW-1:0] pwdata = '0;
  logic          busy = 1'b0;
  logic          done = 1'b0;

  // Instance with two wait states (_w) and zero-wait instance (_z) on the same bus
  logic             pready_w, pslverr_w, start_w, enable_w;
  logic [DW-1:0]    prdata_w;
  logic [1:0]       mode_w;
  logic [NC*DW-1:0] coef_w;
  logic             pready_z, pslverr_z, start_z, enable_z;
  logic [DW-1:0]    prdata_z;
  logic [1:0]       mode_z;
  logic [NC*DW-1:0] coef_z;

  always #5 clk = ~clk;

  apb_filter_regs #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_COEF(NC), .WAIT_CYCLES(2), .CNT_WIDTH(CW)
  ) dut_w (
    .clk(clk), .rst(rst), .i_PADDR(paddr), .i_PSEL(psel), .i_PENABLE(penable),
    .i_PWRITE(pwrite), .i_PWDATA(pwdata), .o_PREADY(pready_w), .o_PRDATA(prdata_w),
    .o_PSLVERR(pslverr_w), .i_busy(busy), .i_done(done), .o_start(start_w),
    .o_enable(enable_w), .o_mode(mode_w), .o_coef(coef_w)
  );

  apb_filter_regs #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_COEF(NC), .WAIT_CYCLES(0), .CNT_WIDTH(CW)
  ) dut_z (
    .clk(clk), .rst(rst), .i_PADDR(paddr), .i_PSEL(psel), .i_PENABLE(penable),
    .i_PWRITE(pwrite), .i_PWDATA(pwdata), .o_PREADY(pready_z), .o_PRDATA(prdata_z),
    .o_PSLVERR(pslverr_z), .i_busy(busy), .i_done(done), .o_start(start_z),
    .o_enable(enable_z), .o_mode(mode_z), .o_coef(coef_z)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model of the register file (tracks dut_w)
  bit       m_en;
  bit [1:0] m_mode;
  bit       m_done;
  bit [7:0] m_coef[NC];

  function automatic bit m_valid(input logic [AW-1:0] a);
    return int'(a) < 2 + int'(NC);
  endfunction

  function automatic logic [7:0] m_read(input logic [AW-1:0] a, input bit busy_v);
    if (a == 0) return {4'b0000, m_mode, m_en, 1'b0};
    if (a == 1) return {6'b000000, m_done, busy_v};
    if (m_valid(a)) return m_coef[int'(a) - 2];
    return 8'h00;
  endfunction

  task automatic m_write(input logic [AW-1:0] a, input logic [7:0] d);
    if (a == 0) begin
      m_en   = d[1];
      m_mode = d[3:2];
    end else if (a == 1) begin
      if (d[1]) m_done = 1'b0;
    end else if (m_valid(a)) begin
      m_coef[int'(a) - 2] = d;
    end
  endtask

  task automatic check_regs(input string tag);
    chk({tag, ".enable"}, 32'(enable_w), 32'(m_en));
    chk({tag, ".mode"}, 32'(mode_w), 32'(m_mode));
    for (int k = 0; k < int'(NC); k++) begin
      chk($sformatf("%s.coef%0d", tag, k), 32'(coef_w[k*DW +: DW]), 32'(m_coef[k]));
    end
  endtask

  // One APB transfer; lat counts access cycles up to and including PREADY (-1 on timeout).
  // Returns just after the PREADY-cycle negedge with PSEL/PENABLE still asserted.
  task automatic xfer(input logic [AW-1:0] a, input logic wr, input logic [7:0] wd,
                      input bit zero_dut, output logic [7:0] rd, output logic err,
                      output int lat);
    @(negedge clk);
    paddr = a; pwrite = wr; pwdata = wd; psel = 1'b1; penable = 1'b0;
    @(negedge clk);
    penable = 1'b1;
    lat = 1;
    #1;
    while (!(zero_dut ? pready_z : pready_w)) begin
      if (lat >= 16) begin
        lat = -1;
        break;
      end
      @(negedge clk);
      #1;
      lat++;
    end
    rd  = zero_dut ? prdata_z : prdata_w;
    err = zero_dut ? pslverr_z : pslverr_w;
  endtask

  task automatic idle();
    @(negedge clk);
    psel = 1'b0; penable = 1'b0;
    #1;
  endtask

  typedef struct {
    logic [AW-1:0] addr;
    logic          wr;
    logic [7:0]    wdata;
    logic [7:0]    exp_rd;
    logic          exp_err;
    logic          exp_start;
  } vec_t;

  vec_t vecs[14];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [7:0] rd;
    logic       err;
    int         lat;

    vecs[0]  = '{10'h002, 1'b1, 8'h5A, 8'h00, 1'b0, 1'b0};
    vecs[1]  = '{10'h002, 1'b0, 8'h00, 8'h5A, 1'b0, 1'b0};
    vecs[2]  = '{10'h000, 1'b1, 8'h0B, 8'h00, 1'b0, 1'b1};
    vecs[3]  = '{10'h000, 1'b0, 8'h00, 8'h0A, 1'b0, 1'b0};
    vecs[4]  = '{10'h3FF, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0};
    vecs[5]  = '{10'h3FF, 1'b1, 8'hFF, 8'h00, 1'b1, 1'b0};
    vecs[6]  = '{10'h002, 1'b0, 8'h00, 8'h5A, 1'b0, 1'b0};
    vecs[7]  = '{10'h000, 1'b0, 8'h00, 8'h0A, 1'b0, 1'b0};
    vecs[8]  = '{10'h00A, 1'b1, 8'h81, 8'h00, 1'b0, 1'b0};
    vecs[9]  = '{10'h00A, 1'b0, 8'h00, 8'h81, 1'b0, 1'b0};
    vecs[10] = '{10'h00B, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0};
    vecs[11] = '{10'h001, 1'b1, 8'hFE, 8'h00, 1'b0, 1'b0};
    vecs[12] = '{10'h000, 1'b1, 8'h04, 8'h00, 1'b0, 1'b0};
    vecs[13] = '{10'h000, 1'b0, 8'h00, 8'h04, 1'b0, 1'b0};

    // ---- 1. reset state, then reset asserted mid-ACCESS ----
    repeat (2) @(negedge clk);
    #1;
    chk("rst.pready", 32'(pready_w), 0);
    chk("rst.pslverr", 32'(pslverr_w), 0);
    chk("rst.prdata", 32'(prdata_w), 0);
    chk("rst.start", 32'(start_w), 0);
    chk("rst.coef", 32'(|coef_w), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    paddr = 10'h002; pwrite = 1'b1; pwdata = 8'h77; psel = 1'b1; penable = 1'b0;
    @(negedge clk);
    penable = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("midrst.pready", 32'(pready_w), 0);
    chk("midrst.pslverr", 32'(pslverr_w), 0);
    chk("midrst.prdata", 32'(prdata_w), 0);
    chk("midrst.start", 32'(start_w), 0);
    @(negedge clk);
    rst = 1'b0; psel = 1'b0; penable = 1'b0;
    @(negedge clk);
    #1;
    chk("midrst.coef_w", 32'(|coef_w), 0);
    chk("midrst.coef_z", 32'(|coef_z), 0);

    // ---- 2-4. directed table ----
    for (int i = 0; i < 14; i++) begin
      xfer(vecs[i].addr, vecs[i].wr, vecs[i].wdata, 1'b0, rd, err, lat);
      chk($sformatf("vec%0d.latency", i), 32'(lat), 3);
      chk($sformatf("vec%0d.prdata", i), 32'(rd), 32'(vecs[i].exp_rd));
      chk($sformatf("vec%0d.pslverr", i), 32'(err), 32'(vecs[i].exp_err));
      if (vecs[i].wr && !vecs[i].exp_err) m_write(vecs[i].addr, vecs[i].wdata);
      idle();
      chk($sformatf("vec%0d.start", i), 32'(start_w), 32'(vecs[i].exp_start));
      check_regs($sformatf("vec%0d", i));
      idle();
      chk($sformatf("vec%0d.start_off", i), 32'(start_w), 0);
    end

    // ---- 5. sticky done, set wins over clear ----
    @(negedge clk);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    xfer(10'h001, 1'b0, 8'h00, 1'b0, rd, err, lat);
    chk("done.after_pulse", 32'(rd), 32'h02);
    idle();
    done = 1'b1;
    xfer(10'h001, 1'b1, 8'h02, 1'b0, rd, err, lat);
    idle();
    done = 1'b0;
    xfer(10'h001, 1'b0, 8'h00, 1'b0, rd, err, lat);
    chk("done.set_wins", 32'(rd), 32'h02);
    idle();
    xfer(10'h001, 1'b1, 8'h02, 1'b0, rd, err, lat);
    idle();
    xfer(10'h001, 1'b0, 8'h00, 1'b0, rd, err, lat);
    chk("done.cleared", 32'(rd), 32'h00);
    idle();
    busy = 1'b1;
    xfer(10'h001, 1'b0, 8'h00, 1'b0, rd, err, lat);
    chk("status.busy", 32'(rd), 32'h01);
    idle();
    busy = 1'b0;
    m_done = 1'b0;

    // ---- randomized transfers against the model ----
    for (int i = 0; i < 60; i++) begin
      logic [AW-1:0] a;
      logic          wr;
      logic [7:0]    wd;
      bit            b;
      logic [7:0]    exp_rd;
      a  = ($urandom_range(0, 7) == 0) ? AW'(10'h3FF) : AW'($urandom_range(0, 15));
      wr = 1'($urandom_range(0, 1));
      wd = 8'($urandom);
      b  = 1'($urandom_range(0, 1));
      busy = b;
      exp_rd = (wr || !m_valid(a)) ? 8'h00 : m_read(a, b);
      xfer(a, wr, wd, 1'b0, rd, err, lat);
      chk($sformatf("rnd%0d.latency", i), 32'(lat), 3);
      chk($sformatf("rnd%0d.prdata a=%0h", i, a), 32'(rd), 32'(exp_rd));
      chk($sformatf("rnd%0d.pslverr a=%0h", i, a), 32'(err), 32'(!m_valid(a)));
      if (wr && m_valid(a)) m_write(a, wd);
      idle();
      chk($sformatf("rnd%0d.start", i), 32'(start_w), 32'(wr && a == 0 && wd[0]));
      check_regs($sformatf("rnd%0d", i));
    end
    busy = 1'b0;

    // ---- 6. abort during wait states, then zero-wait back-to-back ----
    @(negedge clk);
    paddr = 10'h003; pwrite = 1'b1; pwdata = 8'hEE; psel = 1'b1; penable = 1'b0;
    @(negedge clk);
    penable = 1'b1;
    #1;
    chk("abort.pready1", 32'(pready_w), 0);
    @(negedge clk);
    #1;
    chk("abort.pready2", 32'(pready_w), 0);
    @(negedge clk);
    psel = 1'b0; penable = 1'b0;
    #1;
    chk("abort.pready3", 32'(pready_w), 0);
    @(negedge clk);
    #1;
    chk("abort.pready4", 32'(pready_w), 0);
    check_regs("abort");
    xfer(10'h003, 1'b0, 8'h00, 1'b0, rd, err, lat);
    chk("abort.readback", 32'(rd), 32'(m_coef[1]));
    chk("abort.rb_latency", 32'(lat), 3);
    idle();

    xfer(10'h004, 1'b1, 8'h11, 1'b1, rd, err, lat);
    chk("b2b.wr0.latency", 32'(lat), 1);
    xfer(10'h005, 1'b1, 8'h22, 1'b1, rd, err, lat);
    chk("b2b.wr1.latency", 32'(lat), 1);
    xfer(10'h004, 1'b0, 8'h00, 1'b1, rd, err, lat);
    chk("b2b.rd0.latency", 32'(lat), 1);
    chk("b2b.rd0.data", 32'(rd), 32'h11);
    xfer(10'h005, 1'b0, 8'h00, 1'b1, rd, err, lat);
    chk("b2b.rd1.latency", 32'(lat), 1);
    chk("b2b.rd1.data", 32'(rd), 32'h22);
    chk("b2b.rd1.pslverr", 32'(err), 0);
    idle();
    chk("b2b.coef2", 32'(coef_z[2*DW +: DW]), 32'h11);
    chk("b2b.coef3", 32'(coef_z[3*DW +: DW]), 32'h22);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
